// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage operand-forwarding controller.
package fwd_pkg;

    localparam int unsigned FWD_REG_W = 5;
    localparam int unsigned XZR_IDX   = 31;
    localparam int unsigned FWD_CNT_W = 16;

    // ALU operand mux port: register file, EX/MEM result, MEM/WB data, constant zero
    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_ZERO  = 2'd3
    } fwd_port_t;

    // Destination tracking entry for one in-flight instruction
    typedef struct packed {
        logic                 valid;
        logic [FWD_REG_W-1:0] rd;
        logic                 reg_write;
        logic                 mem_read;
    } dest_entry_t;

endpackage

// File: rtl/fwd_operand_match.sv
// Per-operand forwarding select and load-use detection (combinational).
module fwd_operand_match
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W    = FWD_REG_W,
    parameter int unsigned ZERO_REG = XZR_IDX
) (
    input  logic [REG_W-1:0] i_src,
    input  logic             i_use,
    input  dest_entry_t      i_ex_e,
    input  dest_entry_t      i_mem_e,
    output fwd_port_t        o_port,
    output logic             o_load_hit
);

    logic w_is_zero;
    logic w_ex_hit;
    logic w_mem_hit;
    logic w_unused_mem_read;

    assign w_is_zero = (i_src == REG_W'(ZERO_REG));
    assign w_ex_hit  = i_ex_e.valid  & i_ex_e.reg_write  & (i_ex_e.rd  == i_src);
    assign w_mem_hit = i_mem_e.valid & i_mem_e.reg_write & (i_mem_e.rd == i_src);

    // A load in MEM has its data at MEM/WB already, so its load flag is irrelevant here
    assign w_unused_mem_read = i_mem_e.mem_read;

    // Priority select: zero register, unused operand, youngest producer, older producer
    always_comb begin
        o_port = FWD_RF;
        if (w_is_zero) begin
            o_port = FWD_ZERO;
        end else if (!i_use) begin
            o_port = FWD_RF;
        end else if (w_ex_hit) begin
            o_port = FWD_EXMEM;
        end else if (w_mem_hit) begin
            o_port = FWD_MEMWB;
        end
    end

    // Load in EX feeding this operand: data not ready until it reaches MEM/WB
    assign o_load_hit = i_use & w_ex_hit & i_ex_e.mem_read & !w_is_zero;

endmodule

// File: rtl/fwd_select_unit.sv
// Operand-forwarding controller for the EX stage: shadow destination pipeline,
// registered ALU operand selects and one-cycle load-use stall.
// Optional feature macro: FWD_STALL_CNT_EN adds a saturating stall_count output.
module fwd_select_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_W    = FWD_REG_W,
    parameter int unsigned ZERO_REG = XZR_IDX
`ifdef FWD_STALL_CNT_EN
    ,
    parameter int unsigned CNT_W    = FWD_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       ex_fwd_a,
    output logic [1:0]       ex_fwd_b,
    output logic             stall_id
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    dest_entry_t r_ex_e;
    dest_entry_t r_mem_e;
    dest_entry_t r_wb_e;

    fwd_port_t   w_port_a;
    fwd_port_t   w_port_b;
    logic        w_load_hit_a;
    logic        w_load_hit_b;
    logic        w_bubble;
    dest_entry_t w_ex_next;
    logic [1:0]  w_fwd_a_next;
    logic [1:0]  w_fwd_b_next;
    logic        w_unused_wb;

    fwd_operand_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_a (
        .i_src      (id_rn),
        .i_use      (id_use_rn),
        .i_ex_e     (r_ex_e),
        .i_mem_e    (r_mem_e),
        .o_port     (w_port_a),
        .o_load_hit (w_load_hit_a)
    );

    fwd_operand_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_match_b (
        .i_src      (id_rm),
        .i_use      (id_use_rm),
        .i_ex_e     (r_ex_e),
        .i_mem_e    (r_mem_e),
        .o_port     (w_port_b),
        .o_load_hit (w_load_hit_b)
    );

    // Load-use stall; a taken-branch flush squashes the consumer, so it wins
    assign stall_id = id_valid & !flush & (w_load_hit_a | w_load_hit_b);
    assign w_bubble = stall_id | flush | !id_valid;

    // Write-back entry completes the shadow pipe; the register file writes before it reads, so no select uses it
    assign w_unused_wb = ^r_wb_e;

    // Next EX entry and selects: a bubble carries no destination and selects the register file
    always_comb begin
        w_ex_next    = '0;
        w_fwd_a_next = 2'(FWD_RF);
        w_fwd_b_next = 2'(FWD_RF);
        if (!w_bubble) begin
            w_ex_next.valid     = 1'b1;
            w_ex_next.rd        = FWD_REG_W'(id_rd);
            w_ex_next.reg_write = id_reg_write;
            w_ex_next.mem_read  = id_mem_read;
            w_fwd_a_next        = 2'(w_port_a);
            w_fwd_b_next        = 2'(w_port_b);
        end
    end

    // Shadow pipeline and EX-aligned selects advance every clock; stalls never freeze MEM/WB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_e   <= '0;
            r_mem_e  <= '0;
            r_wb_e   <= '0;
            ex_fwd_a <= 2'(FWD_RF);
            ex_fwd_b <= 2'(FWD_RF);
        end else begin
            r_ex_e   <= w_ex_next;
            r_mem_e  <= r_ex_e;
            r_wb_e   <= r_mem_e;
            ex_fwd_a <= w_fwd_a_next;
            ex_fwd_b <= w_fwd_b_next;
        end
    end

`ifdef FWD_STALL_CNT_EN
    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_id && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fwd_select_unit.sv
// Scoreboard bench for fwd_select_unit: driver pushes expected selects, monitor pops and compares.
module tb_fwd_select_unit;

    localparam int unsigned CNT_W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn, id_rm, id_rd;
    logic       id_use_rn, id_use_rm, id_reg_write, id_mem_read, flush;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic       stall_id;
`ifdef FWD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_count;
`endif

    fwd_select_unit #(
        .REG_W    (5),
        .ZERO_REG (31)
`ifdef FWD_STALL_CNT_EN
        ,
        .CNT_W    (CNT_W)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_use_rn    (id_use_rn),
        .id_use_rm    (id_use_rm),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .ex_fwd_a     (ex_fwd_a),
        .ex_fwd_b     (ex_fwd_b),
        .stall_id     (stall_id)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction record as the programmer sees it
    typedef struct {
        bit v;
        int rn;
        int rm;
        bit urn;
        bit urm;
        int rd;
        bit rw;
        bit mr;
        bit fl;
    } instr_t;

    int      checks = 0;
    int      errors = 0;
    instr_t  issued[$];     // instructions that entered EX, youngest first (bubbles recorded as invalid)
    int      exp_q[$];      // expected {a,b} selects, one per cycle
    longint  cnt_model = 0;
    bit      last_stall = 0;
    int      stalls_seen = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operand source from the programmer's view: which in-flight instruction last wrote it
    function automatic int model_port(int src, bit use_it);
        if (src == 31) return 3;
        if (!use_it) return 0;
        for (int d = 0; d < issued.size() && d < 2; d++)
            if (issued[d].v && issued[d].rw && issued[d].rd == src)
                return (d == 0) ? 1 : 2;
        return 0;
    endfunction

    function automatic bit model_stall(instr_t x);
        instr_t p;
        if (!x.v || x.fl || issued.size() == 0) return 0;
        p = issued[0];
        if (!(p.v && p.mr && p.rw) || p.rd == 31) return 0;
        return (x.urn && x.rn == p.rd) || (x.urm && x.rm == p.rd);
    endfunction

    task automatic issue(input instr_t x);
        bit st;
        int pa, pb;
        instr_t ent;
        @(negedge clk);
        id_valid = x.v; id_rn = 5'(x.rn); id_rm = 5'(x.rm);
        id_use_rn = x.urn; id_use_rm = x.urm; id_rd = 5'(x.rd);
        id_reg_write = x.rw; id_mem_read = x.mr; flush = x.fl;
        #1;
        st = model_stall(x);
        check("stall_id", longint'(stall_id), longint'(st));
`ifdef FWD_STALL_CNT_EN
        check("stall_count", longint'(stall_count), cnt_model);
`endif
        if (st || x.fl || !x.v) begin
            pa = 0; pb = 0;
        end else begin
            pa = model_port(x.rn, x.urn);
            pb = model_port(x.rm, x.urm);
        end
        exp_q.push_back(pa * 4 + pb);
        last_stall = st;
        if (st) stalls_seen++;
        @(posedge clk);
        ent = x;
        if (st || x.fl || !x.v) ent.v = 0;
        issued.push_front(ent);
        if (issued.size() > 2) void'(issued.pop_back());
        if (st && cnt_model < (longint'(1) << CNT_W) - 1) cnt_model++;
    endtask

    function automatic instr_t mk(bit v, int rd, int rn, int rm, bit urn, bit urm, bit rw, bit mr, bit fl);
        instr_t x;
        x.v = v; x.rd = rd; x.rn = rn; x.rm = rm; x.urn = urn; x.urm = urm;
        x.rw = rw; x.mr = mr; x.fl = fl;
        return x;
    endfunction

    function automatic int pick_reg();
        int r;
        r = int'($urandom_range(1, 4));
        return (r == 4) ? 31 : r;
    endfunction

    // Monitor: compare registered selects against the oldest expectation each cycle
    initial begin
        int e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ex_fwd_a", longint'(ex_fwd_a), longint'(e / 4));
                check("ex_fwd_b", longint'(ex_fwd_b), longint'(e % 4));
            end
        end
    end

    initial begin
        instr_t x;
        reset = 1'b1;
        id_valid = 0; id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        #2;
        check("reset_fwd_a", longint'(ex_fwd_a), 0);
        check("reset_fwd_b", longint'(ex_fwd_b), 0);
        check("reset_stall", longint'(stall_id), 0);
`ifdef FWD_STALL_CNT_EN
        check("reset_count", longint'(stall_count), 0);
`endif
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // ADD X1; ADD X2 <- X1,X3
        issue(mk(1, 1, 5, 6, 1, 1, 1, 0, 0));
        issue(mk(1, 2, 1, 3, 1, 1, 1, 0, 0));
        // Producer X1, unrelated, consumer of X1 in rm
        issue(mk(1, 1, 5, 6, 1, 1, 1, 0, 0));
        issue(mk(1, 7, 8, 9, 1, 1, 1, 0, 0));
        issue(mk(1, 10, 3, 1, 1, 1, 1, 0, 0));
        // Producer X1 twice, then consumer
        issue(mk(1, 1, 5, 6, 1, 1, 1, 0, 0));
        issue(mk(1, 1, 5, 6, 1, 1, 1, 0, 0));
        issue(mk(1, 11, 1, 3, 1, 1, 1, 0, 0));
        // LDUR X4; SUB reading X4 stalls once, then gets MEM/WB
        issue(mk(1, 4, 31, 0, 1, 0, 1, 1, 0));
        issue(mk(1, 12, 4, 3, 1, 1, 1, 0, 0));
        check("load_use_stalled", longint'(last_stall), 1);
        issue(mk(1, 12, 4, 3, 1, 1, 1, 0, 0));
        // Load writing X31, consumer reading X31
        issue(mk(1, 31, 2, 0, 1, 0, 1, 1, 0));
        issue(mk(1, 13, 31, 31, 1, 1, 1, 0, 0));
        // Load-use hazard with flush
        issue(mk(1, 4, 31, 0, 1, 0, 1, 1, 0));
        issue(mk(1, 14, 4, 4, 1, 1, 1, 0, 1));
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Mid-stream reset with a pending load in EX
        issue(mk(1, 4, 31, 0, 1, 0, 1, 1, 0));
        @(negedge clk);
        reset = 1'b1;
        id_valid = 1; id_rn = 5'd4; id_rm = 5'd4; id_use_rn = 1; id_use_rm = 1;
        id_rd = 5'd15; id_reg_write = 1; id_mem_read = 0; flush = 0;
        #1;
        check("midreset_fwd_a", longint'(ex_fwd_a), 0);
        check("midreset_fwd_b", longint'(ex_fwd_b), 0);
        check("midreset_stall", longint'(stall_id), 0);
        issued.delete();
        cnt_model = 0;
        @(negedge clk);
        reset = 1'b0;
        issue(mk(1, 15, 4, 4, 1, 1, 1, 0, 0));

        // Randomized traffic; a stalled instruction is re-presented as ID would hold it
        x = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                x.v   = ($urandom_range(0, 9) != 0);
                x.rd  = pick_reg();
                x.rn  = pick_reg();
                x.rm  = pick_reg();
                x.urn = ($urandom_range(0, 4) != 0);
                x.urm = ($urandom_range(0, 4) != 0);
                x.rw  = ($urandom_range(0, 5) != 0);
                x.mr  = ($urandom_range(0, 2) == 0);
            end
            x.fl = ($urandom_range(0, 11) == 0);
            issue(x);
        end

`ifdef FWD_STALL_CNT_EN
        // Back-to-back self-dependent loads: one stall every two cycles until saturation
        stalls_seen = 0;
        while (stalls_seen < (1 << CNT_W) + 3)
            issue(mk(1, 4, 4, 0, 1, 0, 1, 1, 0));
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("count_saturated", longint'(stall_count), (longint'(1) << CNT_W) - 1);
`endif

        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
